// File: rtl/priv_1_11_trap_sequencer_if.sv
// Bus bundle between the trap sequencer and its neighbours: the pipeline hazard
// logic, the interrupt sources, the CSR file and pipe_ctrl.
// master : the environment side, which drives requests, CSR values and interrupt levels.
// slave  : the trap sequencer, which drives the acknowledge, the CSR update strobes
//          and the PC redirect.
interface priv_1_11_trap_sequencer_if #(
  parameter int XLEN    = 32,
  parameter int CAUSE_W = 5
);
  // synchronous exception request
  logic               exc_req;
  logic [CAUSE_W-1:0] exc_cause;
  logic [XLEN-1:0]    exc_epc;
  logic [XLEN-1:0]    exc_tval;
  logic               exc_ack;
  // interrupt sources and pending-clear strobes
  logic               ext_int_m;
  logic               timer_int_m;
  logic               soft_int_m;
  logic               clear_ext_int_m;
  logic               clear_timer_int_m;
  logic               clear_soft_int_m;
  logic [XLEN-1:0]    int_epc;
  // current CSR state
  logic [2:0]         mie_en;
  logic               mstatus_mie;
  logic               mstatus_mpie;
  logic [XLEN-3:0]    mtvec_base;
  logic [1:0]         mtvec_mode;
  logic [XLEN-1:0]    mepc;
  // pipeline control
  logic               mret;
  logic               pipe_clear;
  // CSR updates
  logic               mip_rup;
  logic               mepc_rup;
  logic               mcause_rup;
  logic               mtval_rup;
  logic               mstatus_rup;
  logic [2:0]         mip_next;
  logic [XLEN-1:0]    mepc_next;
  logic [XLEN-1:0]    mtval_next;
  logic [XLEN-1:0]    mcause_next;
  logic               mstatus_mie_next;
  logic               mstatus_mpie_next;
  // redirect and status
  logic               intr;
  logic               insert_pc;
  logic [XLEN-1:0]    priv_pc;
  logic               busy;

  modport master (
    output exc_req, exc_cause, exc_epc, exc_tval,
    output ext_int_m, timer_int_m, soft_int_m,
    output clear_ext_int_m, clear_timer_int_m, clear_soft_int_m, int_epc,
    output mie_en, mstatus_mie, mstatus_mpie, mtvec_base, mtvec_mode, mepc,
    output mret, pipe_clear,
    input  exc_ack,
    input  mip_rup, mepc_rup, mcause_rup, mtval_rup, mstatus_rup,
    input  mip_next, mepc_next, mtval_next, mcause_next,
    input  mstatus_mie_next, mstatus_mpie_next,
    input  intr, insert_pc, priv_pc, busy
  );

  modport slave (
    input  exc_req, exc_cause, exc_epc, exc_tval,
    input  ext_int_m, timer_int_m, soft_int_m,
    input  clear_ext_int_m, clear_timer_int_m, clear_soft_int_m, int_epc,
    input  mie_en, mstatus_mie, mstatus_mpie, mtvec_base, mtvec_mode, mepc,
    input  mret, pipe_clear,
    output exc_ack,
    output mip_rup, mepc_rup, mcause_rup, mtval_rup, mstatus_rup,
    output mip_next, mepc_next, mtval_next, mcause_next,
    output mstatus_mie_next, mstatus_mpie_next,
    output intr, insert_pc, priv_pc, busy
  );
endinterface

// File: rtl/priv_1_11_trap_sequencer.sv
// Machine-mode trap/return sequencer.
// This block latches the interrupt sources into a pending register and arbitrates
// interrupts against synchronous exceptions and mret. It waits for the pipeline
// to drain, then issues the CSR update strobes, followed by the PC redirect.
// Ports:
//   CLK  : clock
//   nRST : synchronous active-low reset
//   bus  : slave side of priv_1_11_trap_sequencer_if (requests in; strobes, next-values and redirect out)
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting; selects exception > interrupt > mret
// DRAIN    | trap/return captured, waiting for pipe_clear
// COMMIT   | one cycle of mepc/mcause/mtval/mstatus strobes
// REDIRECT | one cycle insert_pc to the trap vector
// RET      | one cycle mstatus restore plus insert_pc to mepc
module priv_1_11_trap_sequencer #(
  parameter int XLEN    = 32,
  parameter int CAUSE_W = 5
) (
  input logic                        CLK,
  input logic                        nRST,
  priv_1_11_trap_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    COMMIT,
    REDIRECT,
    RET
  } state_t;

  localparam logic [CAUSE_W-1:0] CODE_MEI = CAUSE_W'(11);
  localparam logic [CAUSE_W-1:0] CODE_MSI = CAUSE_W'(3);
  localparam logic [CAUSE_W-1:0] CODE_MTI = CAUSE_W'(7);

  state_t             state_q, state_d;
  logic [2:0]         pend_q, pend_d, pend_src, pend_clr;
  logic [2:0]         elig, int_sel, svc_q;
  logic [CAUSE_W-1:0] int_code, cause_q;
  logic [XLEN-1:0]    epc_q, tval_q;
  logic [XLEN-1:0]    trap_base, vec_off;
  logic               intr_q, ret_q, mip_rup_q;
  logic               int_ok;
  logic               cap_exc, cap_int, cap_ret;

  logic               exc_ack_c;
  logic               trap_rup_c;
  logic               mstatus_rup_c;
  logic               mie_next_c, mpie_next_c;
  logic               insert_pc_c;
  logic [XLEN-1:0]    priv_pc_c;

  // Pending bits are {meip, mtip, msip}. A source that is high in the same cycle
  // as its clear keeps the bit set. The serviced bit is cleared in COMMIT in the
  // same way as an external clear strobe.
  always_comb begin
    pend_src = {bus.ext_int_m, bus.timer_int_m, bus.soft_int_m};
    pend_clr = {bus.clear_ext_int_m, bus.clear_timer_int_m, bus.clear_soft_int_m};
    if (state_q == COMMIT && intr_q) begin
      pend_clr = pend_clr | svc_q;
    end
    pend_d = pend_src | (pend_q & ~pend_clr);
  end

  // Priority order is MEI > MSI > MTI, which is not the order of the bits.
  always_comb begin
    elig     = pend_q & bus.mie_en;
    int_ok   = bus.mstatus_mie & (|elig);
    int_sel  = 3'b000;
    int_code = '0;
    if (elig[2]) begin
      int_sel  = 3'b100;
      int_code = CODE_MEI;
    end else if (elig[0]) begin
      int_sel  = 3'b001;
      int_code = CODE_MSI;
    end else if (elig[1]) begin
      int_sel  = 3'b010;
      int_code = CODE_MTI;
    end
  end

  assign trap_base = {bus.mtvec_base, 2'b00};
  assign vec_off   = {{(XLEN-CAUSE_W-2){1'b0}}, cause_q, 2'b00};

  always_comb begin
    state_d       = state_q;
    cap_exc       = 1'b0;
    cap_int       = 1'b0;
    cap_ret       = 1'b0;
    exc_ack_c     = 1'b0;
    trap_rup_c    = 1'b0;
    mstatus_rup_c = 1'b0;
    mie_next_c    = 1'b0;
    mpie_next_c   = 1'b0;
    insert_pc_c   = 1'b0;
    priv_pc_c     = '0;
    case (state_q)
      IDLE: begin
        // nRST gating keeps exc_ack low while reset is being applied.
        if (nRST) begin
          if (bus.exc_req) begin
            exc_ack_c = 1'b1;
            cap_exc   = 1'b1;
            state_d   = DRAIN;
          end else if (int_ok) begin
            cap_int = 1'b1;
            state_d = DRAIN;
          end else if (bus.mret) begin
            cap_ret = 1'b1;
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (bus.pipe_clear) begin
          state_d = ret_q ? RET : COMMIT;
        end
      end
      COMMIT: begin
        trap_rup_c    = 1'b1;
        mstatus_rup_c = 1'b1;
        mpie_next_c   = bus.mstatus_mie;
        mie_next_c    = 1'b0;
        state_d       = REDIRECT;
      end
      REDIRECT: begin
        insert_pc_c = 1'b1;
        // Only mode 1 vectors, and only for interrupts; modes 2 and 3 are treated as direct.
        if (bus.mtvec_mode == 2'd1 && intr_q) begin
          priv_pc_c = trap_base + vec_off;
        end else begin
          priv_pc_c = trap_base;
        end
        state_d = IDLE;
      end
      RET: begin
        mstatus_rup_c = 1'b1;
        mie_next_c    = bus.mstatus_mpie;
        mpie_next_c   = 1'b1;
        insert_pc_c   = 1'b1;
        priv_pc_c     = bus.mepc;
        state_d       = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q   <= IDLE;
      pend_q    <= '0;
      mip_rup_q <= 1'b0;
      cause_q   <= '0;
      epc_q     <= '0;
      tval_q    <= '0;
      intr_q    <= 1'b0;
      ret_q     <= 1'b0;
      svc_q     <= '0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      // mip_rup is high in the same cycle that mip_next shows the new value.
      mip_rup_q <= (pend_d != pend_q);
      if (cap_exc) begin
        cause_q <= bus.exc_cause;
        epc_q   <= bus.exc_epc;
        tval_q  <= bus.exc_tval;
        intr_q  <= 1'b0;
        ret_q   <= 1'b0;
        svc_q   <= '0;
      end else if (cap_int) begin
        cause_q <= int_code;
        epc_q   <= bus.int_epc;
        tval_q  <= '0;
        intr_q  <= 1'b1;
        ret_q   <= 1'b0;
        svc_q   <= int_sel;
      end else if (cap_ret) begin
        ret_q   <= 1'b1;
      end
    end
  end

  assign bus.exc_ack           = exc_ack_c;
  assign bus.mip_rup           = mip_rup_q;
  assign bus.mip_next          = pend_q;
  assign bus.mepc_rup          = trap_rup_c;
  assign bus.mcause_rup        = trap_rup_c;
  assign bus.mtval_rup         = trap_rup_c;
  assign bus.mstatus_rup       = mstatus_rup_c;
  assign bus.mepc_next         = epc_q;
  assign bus.mtval_next        = tval_q;
  assign bus.mcause_next       = {intr_q, {(XLEN-1-CAUSE_W){1'b0}}, cause_q};
  assign bus.mstatus_mie_next  = mie_next_c;
  assign bus.mstatus_mpie_next = mpie_next_c;
  assign bus.intr              = intr_q;
  assign bus.insert_pc         = insert_pc_c;
  assign bus.priv_pc           = priv_pc_c;
  assign bus.busy              = (state_q != IDLE);

endmodule

// File: tb/tb_priv_1_11_trap_sequencer.sv
module tb_priv_1_11_trap_sequencer;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  priv_1_11_trap_sequencer_if #(.XLEN(32), .CAUSE_W(5)) bus ();

  priv_1_11_trap_sequencer #(.XLEN(32), .CAUSE_W(5)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  typedef struct {
    int          kind;      // 0 exception, 1 interrupt, 2 mret
    logic [4:0]  cause;
    logic [31:0] epc;       // exc_epc or int_epc
    logic [31:0] tval;
    logic [2:0]  src;       // {ext,timer,soft} one-cycle pulse
    logic [2:0]  mie_en;
    logic        mie;
    logic        mpie;
    logic [29:0] base;
    logic [1:0]  mode;
    logic [31:0] mepc;
    logic [31:0] x_epc;
    logic [31:0] x_cause;
    logic [31:0] x_tval;
    logic [31:0] x_pc;
    logic        x_mie_n;
    logic        x_mpie_n;
  } vec_t;

  typedef struct {
    logic        is_ret;
    logic [31:0] epc;
    logic [31:0] cause;
    logic [31:0] tval;
    logic [31:0] pc;
    logic        mie_n;
    logic        mpie_n;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cycle  = 0;
  bit   mon_en = 1'b1;

  always @(posedge CLK) cycle <= cycle + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", nm, act, want, $time);
    end
  endtask

  function automatic exp_t mk_exp(input vec_t v);
    exp_t e;
    e.is_ret = (v.kind == 2);
    e.epc    = v.x_epc;
    e.cause  = v.x_cause;
    e.tval   = v.x_tval;
    e.pc     = v.x_pc;
    e.mie_n  = v.x_mie_n;
    e.mpie_n = v.x_mpie_n;
    return e;
  endfunction

  function automatic vec_t mk(input int kind, input logic [4:0] cause, input logic [31:0] epc,
                              input logic [31:0] tval, input logic [2:0] src, input logic [2:0] mie_en,
                              input logic mie, input logic mpie, input logic [29:0] base,
                              input logic [1:0] mode, input logic [31:0] mepc, input logic [31:0] x_epc,
                              input logic [31:0] x_cause, input logic [31:0] x_tval,
                              input logic [31:0] x_pc, input logic x_mie_n, input logic x_mpie_n);
    vec_t v;
    v.kind = kind; v.cause = cause; v.epc = epc; v.tval = tval; v.src = src;
    v.mie_en = mie_en; v.mie = mie; v.mpie = mpie; v.base = base; v.mode = mode;
    v.mepc = mepc; v.x_epc = x_epc; v.x_cause = x_cause; v.x_tval = x_tval;
    v.x_pc = x_pc; v.x_mie_n = x_mie_n; v.x_mpie_n = x_mpie_n;
    return v;
  endfunction

  // Scoreboard: COMMIT and the redirect are compared against the oldest expectation.
  always @(negedge CLK) begin
    if (mon_en) begin
      if (bus.mcause_rup) begin
        if (exp_q.size() == 0) begin
          chk("commit_unexpected", 32'd1, 32'd0);
        end else begin
          chk("commit_mepc", bus.mepc_next, exp_q[0].epc);
          chk("commit_mcause", bus.mcause_next, exp_q[0].cause);
          chk("commit_mtval", bus.mtval_next, exp_q[0].tval);
          chk("commit_rups", {28'd0, bus.mepc_rup, bus.mtval_rup, bus.mstatus_rup, bus.insert_pc},
              32'b1110);
          chk("commit_mie_next", {31'd0, bus.mstatus_mie_next}, 32'd0);
          chk("commit_mpie_next", {31'd0, bus.mstatus_mpie_next}, {31'd0, exp_q[0].mpie_n});
        end
      end
      if (bus.insert_pc) begin
        if (exp_q.size() == 0) begin
          chk("redirect_unexpected", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("redirect_pc", bus.priv_pc, e.pc);
          chk("redirect_mstatus_rup", {31'd0, bus.mstatus_rup}, {31'd0, e.is_ret});
          if (e.is_ret) begin
            chk("ret_mie_next", {31'd0, bus.mstatus_mie_next}, {31'd0, e.mie_n});
            chk("ret_mpie_next", {31'd0, bus.mstatus_mpie_next}, {31'd0, e.mpie_n});
          end
        end
      end
    end
  end

  // Wait, starting at the current negedge, for insert_pc; returns the cycle it was seen.
  task automatic wait_insert(input string nm, output int t_ins);
    bit got;
    got = 1'b0;
    t_ins = -1;
    for (int i = 0; i < 50 && !got; i++) begin
      #1;
      if (bus.insert_pc) begin
        got = 1'b1;
        t_ins = cycle;
      end else begin
        @(negedge CLK);
      end
    end
    if (!got) begin
      chk({nm, "_timeout"}, 32'd0, 32'd1);
      exp_q.delete();
    end
  endtask

  // Called at a negedge with the FSM idle; returns at the negedge of the following idle cycle.
  task automatic apply(input vec_t v, input int idx);
    int t_ack, t_ins;
    bit got;
    bus.mtvec_base   = v.base;
    bus.mtvec_mode   = v.mode;
    bus.mie_en       = v.mie_en;
    bus.mstatus_mie  = v.mie;
    bus.mstatus_mpie = v.mpie;
    bus.mepc         = v.mepc;
    bus.pipe_clear   = 1'b1;
    exp_q.push_back(mk_exp(v));
    t_ack = 0;
    case (v.kind)
      0: begin
        bus.exc_req   = 1'b1;
        bus.exc_cause = v.cause;
        bus.exc_epc   = v.epc;
        bus.exc_tval  = v.tval;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
          #1;
          if (bus.exc_ack) begin
            got = 1'b1;
            t_ack = cycle;
          end else begin
            @(negedge CLK);
          end
        end
        chk($sformatf("vec%0d_ack", idx), {31'd0, got}, 32'd1);
        @(negedge CLK);
        bus.exc_req = 1'b0;
        chk($sformatf("vec%0d_ack_single", idx), {31'd0, bus.exc_ack}, 32'd0);
      end
      1: begin
        bus.int_epc = v.epc;
        if (v.src != 3'b000) begin
          {bus.ext_int_m, bus.timer_int_m, bus.soft_int_m} = v.src;
          @(negedge CLK);
          {bus.ext_int_m, bus.timer_int_m, bus.soft_int_m} = 3'b000;
        end
      end
      default: begin
        bus.mret = 1'b1;
      end
    endcase
    wait_insert($sformatf("vec%0d", idx), t_ins);
    bus.mret = 1'b0;
    if (v.kind == 0 && t_ins >= 0) chk($sformatf("vec%0d_latency", idx), t_ins - t_ack, 32'd3);
    if (v.kind != 2) chk($sformatf("vec%0d_intr", idx), {31'd0, bus.intr}, {31'd0, v.kind == 1});
    @(negedge CLK);
    #1;
    chk($sformatf("vec%0d_idle", idx), {31'd0, bus.busy}, 32'd0);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_strobes"}, {24'd0, bus.busy, bus.mip_rup, bus.mepc_rup, bus.mcause_rup,
                           bus.mtval_rup, bus.mstatus_rup, bus.insert_pc, bus.exc_ack}, 32'd0);
    chk({nm, "_flags"}, {28'd0, bus.intr, bus.mstatus_mie_next, bus.mstatus_mpie_next, 1'b0}, 32'd0);
    chk({nm, "_mip"}, {29'd0, bus.mip_next}, 32'd0);
    chk({nm, "_mepc"}, bus.mepc_next, 32'd0);
    chk({nm, "_mcause"}, bus.mcause_next, 32'd0);
    chk({nm, "_mtval"}, bus.mtval_next, 32'd0);
    chk({nm, "_pc"}, bus.priv_pc, 32'd0);
  endtask

  vec_t tbl[11];

  initial begin
    int n;
    bus.exc_req = 0; bus.exc_cause = 0; bus.exc_epc = 0; bus.exc_tval = 0;
    bus.ext_int_m = 0; bus.timer_int_m = 0; bus.soft_int_m = 0;
    bus.clear_ext_int_m = 0; bus.clear_timer_int_m = 0; bus.clear_soft_int_m = 0;
    bus.int_epc = 0; bus.mie_en = 0; bus.mstatus_mie = 0; bus.mstatus_mpie = 0;
    bus.mtvec_base = 0; bus.mtvec_mode = 0; bus.mepc = 0; bus.mret = 0; bus.pipe_clear = 1;

    //            kind cause epc           tval          src     mie_en  mie mpie base          mode mepc
    //            x_epc         x_cause       x_tval        x_pc          mie_n mpie_n
    tbl[0]  = mk(0, 5'd2,  32'h100,      32'hDEAD,     3'b000, 3'b111, 1, 0, 30'h80,       0, 0,
                 32'h100,      32'h2,        32'hDEAD,     32'h200,      0, 1);
    tbl[1]  = mk(0, 5'd13, 32'hFFFFFFFC, 32'h12345678, 3'b000, 3'b000, 0, 0, 30'h100,      1, 0,
                 32'hFFFFFFFC, 32'hD,        32'h12345678, 32'h400,      0, 0);
    tbl[2]  = mk(0, 5'd5,  32'h44,       32'h0,        3'b000, 3'b000, 1, 1, 30'h3FFFFFFF, 3, 0,
                 32'h44,       32'h5,        32'h0,        32'hFFFFFFFC, 0, 1);
    tbl[3]  = mk(1, 5'd0,  32'h500,      32'h0,        3'b110, 3'b111, 1, 0, 30'h100,      1, 0,
                 32'h500,      32'h8000000B, 32'h0,        32'h42C,      0, 1);
    tbl[4]  = mk(1, 5'd0,  32'h504,      32'h0,        3'b000, 3'b111, 1, 0, 30'h100,      1, 0,
                 32'h504,      32'h80000007, 32'h0,        32'h41C,      0, 1);
    tbl[5]  = mk(1, 5'd0,  32'h508,      32'h0,        3'b001, 3'b001, 1, 0, 30'h100,      1, 0,
                 32'h508,      32'h80000003, 32'h0,        32'h40C,      0, 1);
    tbl[6]  = mk(1, 5'd0,  32'h510,      32'h0,        3'b011, 3'b111, 1, 0, 30'h100,      1, 0,
                 32'h510,      32'h80000003, 32'h0,        32'h40C,      0, 1);
    tbl[7]  = mk(1, 5'd0,  32'h514,      32'h0,        3'b000, 3'b111, 1, 0, 30'h100,      1, 0,
                 32'h514,      32'h80000007, 32'h0,        32'h41C,      0, 1);
    tbl[8]  = mk(2, 5'd0,  32'h0,        32'h0,        3'b000, 3'b000, 0, 1, 30'h100,      0, 32'h80,
                 32'h0,        32'h0,        32'h0,        32'h80,       1, 1);
    tbl[9]  = mk(2, 5'd0,  32'h0,        32'h0,        3'b000, 3'b000, 1, 0, 30'h100,      0, 32'hABC0,
                 32'h0,        32'h0,        32'h0,        32'hABC0,     0, 1);
    tbl[10] = mk(1, 5'd0,  32'h50C,      32'h0,        3'b100, 3'b100, 1, 0, 30'h3FFFFFFF, 1, 0,
                 32'h50C,      32'h8000000B, 32'h0,        32'h28,       0, 1);

    // reset state
    repeat (3) @(negedge CLK);
    #1;
    chk_zero("reset");
    nRST = 1'b1;
    @(negedge CLK);

    for (int i = 0; i < 11; i++) apply(tbl[i], i);

    // pipe_clear low for 5 cycles holds DRAIN; COMMIT the cycle after it rises
    bus.mtvec_base = 30'h80; bus.mtvec_mode = 0; bus.mstatus_mie = 1; bus.mie_en = 0;
    bus.pipe_clear = 0;
    bus.exc_req = 1; bus.exc_cause = 5'd7; bus.exc_epc = 32'h300; bus.exc_tval = 32'h0;
    begin
      exp_t e;
      e.is_ret = 0; e.epc = 32'h300; e.cause = 32'h7; e.tval = 32'h0;
      e.pc = 32'h200; e.mie_n = 0; e.mpie_n = 1;
      exp_q.push_back(e);
    end
    #1;
    chk("drain_ack", {31'd0, bus.exc_ack}, 32'd1);
    @(negedge CLK);
    bus.exc_req = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("drain_hold%0d", i),
          {29'd0, bus.busy, bus.mcause_rup | bus.mstatus_rup, bus.insert_pc}, 32'b100);
      @(negedge CLK);
    end
    bus.pipe_clear = 1;
    @(negedge CLK);
    #1;
    chk("drain_commit", {31'd0, bus.mcause_rup}, 32'd1);
    @(negedge CLK);
    #1;
    chk("drain_redirect", {31'd0, bus.insert_pc}, 32'd1);
    @(negedge CLK);

    // exception and interrupt eligible in the same cycle
    bus.mstatus_mie = 0; bus.mie_en = 3'b100; bus.ext_int_m = 1;
    @(negedge CLK);
    bus.ext_int_m = 0;
    #1;
    chk("coinc_pending", {29'd0, bus.mip_next}, 32'b100);
    chk("coinc_mip_rup", {31'd0, bus.mip_rup}, 32'd1);
    bus.mtvec_base = 30'h100; bus.mtvec_mode = 1; bus.mstatus_mie = 1; bus.int_epc = 32'h700;
    bus.exc_req = 1; bus.exc_cause = 5'd4; bus.exc_epc = 32'h600; bus.exc_tval = 32'h77;
    begin
      exp_t e;
      e.is_ret = 0; e.epc = 32'h600; e.cause = 32'h4; e.tval = 32'h77;
      e.pc = 32'h400; e.mie_n = 0; e.mpie_n = 1;
      exp_q.push_back(e);
      e.epc = 32'h700; e.cause = 32'h8000000B; e.tval = 32'h0; e.pc = 32'h42C;
      exp_q.push_back(e);
    end
    #1;
    chk("coinc_ack", {31'd0, bus.exc_ack}, 32'd1);
    @(negedge CLK);
    bus.exc_req = 0;
    n = 0;
    for (int i = 0; i < 40 && n < 2; i++) begin
      @(negedge CLK);
      #1;
      if (bus.mcause_rup) chk($sformatf("coinc_intr_trap%0d", n), {31'd0, bus.intr}, {31'd0, n == 1});
      if (bus.insert_pc) n++;
    end
    chk("coinc_both_serviced", n, 32'd2);
    @(negedge CLK);
    #1;
    chk("coinc_mip_cleared", {29'd0, bus.mip_next}, 32'd0);

    // source and clear in the same cycle: set wins
    bus.mstatus_mie = 0;
    bus.soft_int_m = 1; bus.clear_soft_int_m = 1;
    @(negedge CLK);
    bus.soft_int_m = 0; bus.clear_soft_int_m = 0;
    #1;
    chk("setwins_mip", {29'd0, bus.mip_next}, 32'b001);
    chk("setwins_mip_rup", {31'd0, bus.mip_rup}, 32'd1);
    @(negedge CLK);
    #1;
    chk("setwins_mip_rup_quiet", {31'd0, bus.mip_rup}, 32'd0);
    bus.clear_soft_int_m = 1;
    @(negedge CLK);
    bus.clear_soft_int_m = 0;
    #1;
    chk("clear_mip", {29'd0, bus.mip_next}, 32'd0);
    chk("clear_mip_rup", {31'd0, bus.mip_rup}, 32'd1);

    // reset applied in the middle of COMMIT
    mon_en = 0;
    bus.timer_int_m = 1;
    @(negedge CLK);
    bus.timer_int_m = 0;
    bus.mtvec_mode = 0; bus.pipe_clear = 1;
    bus.exc_req = 1; bus.exc_cause = 5'd1; bus.exc_epc = 32'h900; bus.exc_tval = 32'h5;
    @(negedge CLK);
    bus.exc_req = 0;
    @(negedge CLK);
    #1;
    chk("rst_mid_commit_reached", {31'd0, bus.mcause_rup}, 32'd1);
    nRST = 0;
    @(negedge CLK);
    #1;
    chk_zero("rst_mid");
    nRST = 1;
    @(negedge CLK);
    #1;
    chk("rst_after_no_redirect", {30'd0, bus.busy, bus.insert_pc}, 32'd0);
    mon_en = 1;

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
